// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with 1-cycle registered read.
// Clears the RAM after reset, then arbitrates with a bounded-burst owner priority.
module mem_arbiter #(
   parameter int unsigned  DEPTH     = 128,
   parameter int unsigned  WIDTH     = 16,
   parameter int unsigned  MAX_BURST = 4,
   localparam int unsigned AWIDTH    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [AWIDTH-1:0] addr [2],
   input  logic [WIDTH-1:0]  wdata [2],
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [WIDTH-1:0]  rdata,
   output logic              init_done,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_din,
   input  logic [WIDTH-1:0]  mem_dout
);

   localparam int unsigned       BW       = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0]     BurstMax = BW'(MAX_BURST);
   localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(DEPTH - 1);

   typedef enum logic {StInit, StRun} state_e;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] clr_q, clr_d;
   logic              owner_q, owner_d;
   logic [BW-1:0]     burst_q, burst_d;
   logic              init_done_q, init_done_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic              sel;

   always_comb begin
      state_d     = state_q;
      clr_d       = clr_q;
      owner_d     = owner_q;
      burst_d     = burst_q;
      init_done_d = init_done_q;
      rvalid_d    = '0;
      gnt         = '0;
      sel         = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_din     = '0;
      case (state_q)
         StInit: begin
            mem_wr   = 1'b1;
            mem_addr = clr_q;
            clr_d    = clr_q + 1'b1;
            if (clr_q == LastAddr) begin
               state_d     = StRun;
               init_done_d = 1'b1;
               clr_d       = '0;
            end
         end
         StRun: begin
            // On contention the owner keeps the port only mid-burst; otherwise it alternates.
            if (&req) begin
               if (burst_q != '0 && burst_q < BurstMax) sel = owner_q;
               else sel = ~owner_q;
               gnt = sel ? 2'b10 : 2'b01;
            end else if (req[0]) begin
               sel = 1'b0;
               gnt = 2'b01;
            end else if (req[1]) begin
               sel = 1'b1;
               gnt = 2'b10;
            end
            if (gnt != '0) begin
               mem_wr   = we[sel];
               mem_addr = addr[sel];
               mem_din  = wdata[sel];
               rvalid_d = gnt & ~we;
               if (sel == owner_q) begin
                  burst_d = (burst_q == BurstMax) ? burst_q : burst_q + 1'b1;
               end else begin
                  owner_d = sel;
                  burst_d = BW'(1);
               end
            end else begin
               burst_d = '0;
            end
         end
         default: state_d = StInit;
      endcase
      if (rst) begin
         gnt    = '0;
         mem_wr = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StInit;
         clr_q       <= '0;
         owner_q     <= 1'b1;
         burst_q     <= '0;
         init_done_q <= 1'b0;
         rvalid_q    <= '0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         owner_q     <= owner_d;
         burst_q     <= burst_d;
         init_done_q <= init_done_d;
         rvalid_q    <= rvalid_d;
      end
   end

   // A read accepted just before reset must not surface during the reset cycle.
   assign rvalid    = rst ? 2'b00 : rvalid_q;
   assign rdata     = mem_dout;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural RAM, reference memory image and
// a queue of expected read returns checked against rvalid/rdata.
module tb_mem_arbiter;

   localparam int DEPTH = 128;

   typedef struct {
      logic [1:0]  rv;
      logic [15:0] data;
      int          due;
   } sb_entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, we;
   logic [6:0]  addr [2];
   logic [15:0] wdata [2];
   logic [1:0]  gnt, rvalid;
   logic [15:0] rdata;
   logic        init_done, mem_wr;
   logic [6:0]  mem_addr;
   logic [15:0] mem_din, mem_dout;

   logic [15:0] ram [DEPTH];
   logic        ram_seeded = 1'b0;
   logic [15:0] ref_mem [DEPTH];
   sb_entry_t   exp_q [$];
   sb_entry_t   mon_e;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .init_done (init_done),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Seeded with a non-zero pattern so a missed clear shows up in read data.
   always @(posedge clk) begin
      if (!ram_seeded) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= 16'hDEAD;
         ram_seeded <= 1'b1;
      end else begin
         if (mem_wr) ram[mem_addr] <= mem_din;
         mem_dout <= ram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      if (rvalid !== 2'b00) begin
         if (exp_q.size() == 0) begin
            check("rv_unexpected", {30'd0, rvalid}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rv_who", {30'd0, rvalid}, {30'd0, mon_e.rv});
            check("rdata", {16'd0, rdata}, {16'd0, mon_e.data});
            check("rv_cycle", cyc, mon_e.due);
         end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
         mon_e = exp_q.pop_front();
         check("rv_missing", {30'd0, rvalid}, {30'd0, mon_e.rv});
      end
   end

   task automatic drive(input string tag, input logic [1:0] r, input logic [1:0] w,
                        input int a0, input int a1, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] eg);
      sb_entry_t e;
      int        s;
      req      = r;
      we       = w;
      addr[0]  = 7'(a0);
      addr[1]  = 7'(a1);
      wdata[0] = d0;
      wdata[1] = d1;
      @(negedge clk);
      check({tag, "_gnt"}, {30'd0, gnt}, {30'd0, eg});
      check({tag, "_wr"}, {31'd0, mem_wr}, {31'd0, |(eg & w)});
      if (eg != 2'b00) begin
         s = eg[1] ? 1 : 0;
         check({tag, "_addr"}, {25'd0, mem_addr}, {25'd0, addr[s]});
         if (w[s]) begin
            check({tag, "_din"}, {16'd0, mem_din}, {16'd0, wdata[s]});
            ref_mem[addr[s]] = wdata[s];
         end else begin
            e.rv   = eg;
            e.data = ref_mem[addr[s]];
            e.due  = cyc + 1;
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive("idle", 2'b00, 2'b00, 0, 0, 16'h0, 16'h0, 2'b00);
   endtask

   // Requests stay high through reset and clear to prove no grant leaks out of INIT.
   task automatic run_init();
      rst = 1'b1;
      req = 2'b11;
      we  = 2'b00;
      @(posedge clk);
      @(negedge clk);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_gnt", {30'd0, gnt}, 32'd0);
      check("rst_rvalid", {30'd0, rvalid}, 32'd0);
      check("rst_wr", {31'd0, mem_wr}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         check("init_wr", {31'd0, mem_wr}, 32'd1);
         check("init_addr", {25'd0, mem_addr}, i);
         check("init_din", {16'd0, mem_din}, 32'd0);
         check("init_gnt", {30'd0, gnt}, 32'd0);
         check("init_rvalid", {30'd0, rvalid}, 32'd0);
         if (i == 0 || i == DEPTH - 1) check("init_done_low", {31'd0, init_done}, 32'd0);
      end
      @(posedge clk);
      #1 req = 2'b00;
      @(negedge clk);
      check("init_done_high", {31'd0, init_done}, 32'd1);
      check("run_idle_wr", {31'd0, mem_wr}, 32'd0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] pat [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b01, 2'b01, 2'b01, 2'b01};
      rst      = 1'b1;
      req      = 2'b00;
      we       = 2'b00;
      addr[0]  = '0;
      addr[1]  = '0;
      wdata[0] = '0;
      wdata[1] = '0;
      run_init();

      // A writes then reads address 5
      drive("wr_a", 2'b01, 2'b01, 5, 0, 16'h1234, 16'h0, 2'b01);
      drive("rd_a", 2'b01, 2'b00, 5, 0, 16'h0, 16'h0, 2'b01);
      idle();

      // Unwritten address reads back as cleared
      drive("rd_b77", 2'b10, 2'b00, 0, 77, 16'h0, 16'h0, 2'b10);
      idle();

      drive("seed_a", 2'b01, 2'b01, 10, 0, 16'hAAAA, 16'h0, 2'b01);
      drive("seed_b", 2'b10, 2'b10, 0, 20, 16'h0, 16'h5555, 2'b10);
      idle();

      // Sustained contention: bursts of MAX_BURST alternate, starting with A
      for (int k = 0; k < 12; k++) drive("burst", 2'b11, 2'b00, 10, 20, 16'h0, 16'h0, pat[k]);
      idle();

      // An idle cycle ends A's burst, so a following tie goes to B
      drive("a_only0", 2'b01, 2'b00, 10, 0, 16'h0, 16'h0, 2'b01);
      drive("a_only1", 2'b01, 2'b00, 10, 0, 16'h0, 16'h0, 2'b01);
      idle();
      drive("tie_b", 2'b11, 2'b00, 10, 20, 16'h0, 16'h0, 2'b10);
      idle();

      // Uncontended grants saturate burst_cnt; the next tie must switch owner
      for (int k = 0; k < 6; k++) drive("b_sat", 2'b10, 2'b00, 0, 20, 16'h0, 16'h0, 2'b10);
      drive("sat_tie", 2'b11, 2'b00, 10, 20, 16'h0, 16'h0, 2'b01);
      idle();

      // Contended writes, then reads of both results
      drive("ww", 2'b11, 2'b11, 30, 31, 16'h1111, 16'h2222, 2'b10);
      drive("wa", 2'b01, 2'b01, 30, 0, 16'h1111, 16'h0, 2'b01);
      drive("rr", 2'b11, 2'b00, 30, 31, 16'h0, 16'h0, 2'b01);
      drive("rb", 2'b10, 2'b00, 0, 31, 16'h0, 16'h0, 2'b10);
      idle();

      // Reset right after a read accept: the return must be suppressed
      drive("rd_pre_rst", 2'b01, 2'b00, 5, 0, 16'h0, 16'h0, 2'b01);
      void'(exp_q.pop_back());
      rst = 1'b1;
      req = 2'b11;
      @(negedge clk);
      check("rst_rv_supp", {30'd0, rvalid}, 32'd0);
      check("rst_gnt_run", {30'd0, gnt}, 32'd0);
      run_init();

      // Earlier data is wiped by the restarted clear
      drive("rd_after_rst", 2'b01, 2'b00, 5, 0, 16'h0, 16'h0, 2'b01);
      idle();
      idle();
      idle();
      check("sb_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
